// File: rtl/fetch_ifid.sv
// Fetch stage with integrated IF/ID pipeline register.
// Issues level-held read requests to a multi-cycle instruction memory, captures
// returned words with their PC+2, absorbs one word in a skid buffer while decode
// is stalled, and handles decode/execute redirects and HALT.
// Optional: define FETCH_PERF_CNT_EN to add perf_fetched / perf_bubbles counters.
module fetch_ifid #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        stall,
    input  logic        redir_d,
    input  logic [15:0] redir_d_target,
    input  logic        redir_x,
    input  logic [15:0] redir_x_target,
    output logic [15:0] Instruction,
    output logic [15:0] PC_plus_two,
    output logic        valid,
    output logic [15:0] PC,
    output logic        err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_bubbles
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [4:0] OP_HALT = 5'b00000;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] ppt_q, ppt_d;
    logic        valid_q, valid_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_ppt_q, skid_ppt_d;

    logic        redir;
    logic [15:0] redir_tgt;
    logic [15:0] pc_inc;
    logic        halt_data;
    logic        halt_skid;
    logic        load_word;
    logic        load_bubble;
    logic [15:0] word_instr;
    logic [15:0] word_ppt;

    // Execute redirect wins over decode redirect; PC+2 wraps naturally at 16 bits.
    assign redir     = redir_x | redir_d;
    assign redir_tgt = redir_x ? redir_x_target : redir_d_target;
    assign pc_inc    = pc_q + 16'd2;
    assign halt_data = (imem_data[15:11] == OP_HALT);
    assign halt_skid = (skid_instr_q[15:11] == OP_HALT);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            ppt_q        <= 16'h0000;
            valid_q      <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_ppt_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            ppt_q        <= ppt_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_ppt_q   <= skid_ppt_d;
        end
    end

    // Next-state logic: redirects override everything; an unanswered request must drain.
    always_comb begin
        state_d = state_q;
        if (redir) begin
            if ((state_q == S_FETCH || state_q == S_DRAIN) && !imem_done)
                state_d = S_DRAIN;
            else
                state_d = S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    // A word caught under stall parks in the skid buffer; HALT is
                    // honoured once that word actually reaches IF/ID.
                    if (imem_done) begin
                        if (stall)          state_d = S_HOLD;
                        else if (halt_data) state_d = S_HALTED;
                        else                state_d = S_FETCH;
                    end
                end
                S_HOLD: begin
                    if (!stall) state_d = halt_skid ? S_HALTED : S_FETCH;
                end
                S_DRAIN: begin
                    if (imem_done) state_d = S_FETCH;
                end
                default: state_d = S_HALTED;
            endcase
        end
    end

    // Memory request output: active while fetching or while waiting out a stale request.
    always_comb begin
        imem_rd = (state_q == S_FETCH) || (state_q == S_DRAIN);
    end

    // PC / skid buffer update and selection of what IF/ID should load this cycle.
    always_comb begin
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_ppt_d   = skid_ppt_q;
        load_word    = 1'b0;
        load_bubble  = 1'b0;
        word_instr   = skid_instr_q;
        word_ppt     = skid_ppt_q;
        if (redir) begin
            pc_d         = redir_tgt;
            load_bubble  = 1'b1;
            skid_instr_d = NOP_INSTR;
            skid_ppt_d   = 16'h0000;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (imem_done) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            skid_instr_d = imem_data;
                            skid_ppt_d   = pc_inc;
                        end else begin
                            load_word  = 1'b1;
                            word_instr = imem_data;
                            word_ppt   = pc_inc;
                        end
                    end else if (!stall) begin
                        load_bubble = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) load_word = 1'b1;
                end
                default: begin
                    // DRAIN and HALTED deliver nothing; bubble unless decode holds IF/ID.
                    if (!stall) load_bubble = 1'b1;
                end
            endcase
        end
    end

    // IF/ID register input: a real word, a bubble, or hold. PC+2 is kept on bubbles.
    always_comb begin
        instr_d = instr_q;
        ppt_d   = ppt_q;
        valid_d = valid_q;
        if (load_word) begin
            instr_d = word_instr;
            ppt_d   = word_ppt;
            valid_d = 1'b1;
        end else if (load_bubble) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign Instruction = instr_q;
    assign PC_plus_two = ppt_q;
    assign valid       = valid_q;

    // Flags undriven/contended memory data; reduces to constant 0 in synthesis.
    assign err = !rst && imem_done && $isunknown(imem_data);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetched_q, fetched_d;
    logic [15:0] bubbles_q, bubbles_d;

    // Saturating event counters for IF/ID loads.
    always_comb begin
        fetched_d = fetched_q;
        bubbles_d = bubbles_q;
        if (load_word && (fetched_q != 16'hFFFF))   fetched_d = fetched_q + 16'd1;
        if (load_bubble && (bubbles_q != 16'hFFFF)) bubbles_d = bubbles_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= 16'h0000;
            bubbles_q <= 16'h0000;
        end else begin
            fetched_q <= fetched_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

endmodule
